// File: rtl/seq_mul_accumulate_unit.sv
// Iterative 32x32 shift-add multiply-accumulate for MUL/MLA/xMULL/xMLAL.
// Optional early exit on zero remaining multiplier: SEQ_MUL_EARLY_TERMINATE_EN.
module seq_mul_accumulate_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [63:0] acc_in,
  input  logic        is_signed,
  input  logic        accumulate,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [4:0]  r_cnt;
  logic [63:0] r_sum;
  logic [63:0] r_acc;
  logic        r_acc_en;
  logic        r_neg;
  logic        r_out_valid;
  logic [63:0] r_product;

  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [63:0] w_pp;
  logic [31:0] w_mplier_nxt;
  logic        w_last;
  logic [63:0] w_signed_sum;
  logic [63:0] w_fix;

  // -2^31 negates to itself, which is the correct unsigned magnitude
  assign w_mag_a = (is_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign w_mag_b = (is_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;

  assign w_pp = r_mplier[0] ? ({32'd0, r_mcand} << r_cnt) : 64'd0;
  assign w_mplier_nxt = {1'b0, r_mplier[31:1]};

`ifdef SEQ_MUL_EARLY_TERMINATE_EN
  assign w_last = (r_cnt == 5'd31) || (w_mplier_nxt == 32'd0);
`else
  assign w_last = (r_cnt == 5'd31);
`endif

  assign w_signed_sum = r_neg ? (~r_sum + 64'd1) : r_sum;
  assign w_fix = w_signed_sum + (r_acc_en ? r_acc : 64'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mcand     <= 32'd0;
      r_mplier    <= 32'd0;
      r_cnt       <= 5'd0;
      r_sum       <= 64'd0;
      r_acc       <= 64'd0;
      r_acc_en    <= 1'b0;
      r_neg       <= 1'b0;
      r_out_valid <= 1'b0;
      r_product   <= 64'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_neg    <= is_signed & (op_a[31] ^ op_b[31]);
            r_acc    <= acc_in;
            r_acc_en <= accumulate;
            r_sum    <= 64'd0;
            r_cnt    <= 5'd0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum    <= r_sum + w_pp;
          r_mplier <= w_mplier_nxt;
          r_cnt    <= r_cnt + 5'd1;
          if (w_last) r_state <= S_FIXUP;
        end
        S_FIXUP: begin
          r_product   <= w_fix;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN) || (r_state == S_FIXUP);
  assign out_valid = r_out_valid;
  assign product   = r_product;

endmodule
